// File: rtl/apb_slave_regbank.sv
// APB completer holding DEPTH x 32-bit registers at BASE_ADDR, with WAIT_CYCLES wait states.
// Optional macro APB_SLVERR_EN adds the pslverr port and flags out-of-range accesses.
module apb_slave_regbank #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
`ifdef APB_SLVERR_EN
  output logic        pslverr,
`endif
  output logic [31:0] prdata,
  output logic        pready
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [3:0]       cnt_r;
  logic [IDX_W-1:0] lat_idx_r;
  logic             lat_write_r;
  logic             lat_in_range_r;
  logic [31:0]      lat_wdata_r;
  logic [31:0]      prdata_r;
  logic             pready_r;
  logic             pslverr_r;
  logic [31:0]      regs_r [DEPTH];

  logic [31:0]      off_s;
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  logic             unused_s;

  // Byte offsets within a word are don't-care; only the word index decodes.
  assign off_s      = paddr - BASE_ADDR;
  assign in_range_s = (off_s[31:2] < DEPTH_W);
  assign idx_s      = off_s[2 +: IDX_W];
  assign unused_s   = ^off_s[1:0];

  // Read data is only returned for in-range reads; writes leave the bus at zero.
  function automatic logic [31:0] read_value(input logic is_write, input logic ok,
                                             input logic [31:0] word);
    return (!is_write && ok) ? word : 32'h0000_0000;
  endfunction

  // Transfer sequencing, registered response and register-bank commit.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      pready_r       <= 1'b0;
      prdata_r       <= 32'h0000_0000;
      pslverr_r      <= 1'b0;
      lat_idx_r      <= '0;
      lat_write_r    <= 1'b0;
      lat_in_range_r <= 1'b0;
      lat_wdata_r    <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (psel && !penable) begin
            lat_idx_r      <= idx_s;
            lat_write_r    <= pwrite;
            lat_in_range_r <= in_range_s;
            lat_wdata_r    <= pwdata;
            cnt_r          <= WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
              state_r   <= ST_DONE;
              pready_r  <= 1'b1;
              prdata_r  <= read_value(pwrite, in_range_s, regs_r[idx_s]);
              pslverr_r <= !in_range_s;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
          end else if (penable) begin
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
              state_r   <= ST_DONE;
              pready_r  <= 1'b1;
              prdata_r  <= read_value(lat_write_r, lat_in_range_r, regs_r[lat_idx_r]);
              pslverr_r <= !lat_in_range_r;
            end
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          pready_r  <= 1'b0;
          prdata_r  <= 32'h0000_0000;
          pslverr_r <= 1'b0;
          if (lat_write_r && lat_in_range_r) begin
            regs_r[lat_idx_r] <= lat_wdata_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= 4'd0;
          pready_r  <= 1'b0;
          prdata_r  <= 32'h0000_0000;
          pslverr_r <= 1'b0;
        end
      endcase
    end
  end

  assign prdata = prdata_r;
  assign pready = pready_r;

`ifdef APB_SLVERR_EN
  assign pslverr = pslverr_r;
`else
  logic unused_err_s;
  assign unused_err_s = pslverr_r;
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench: three completers (WAIT_CYCLES 0, 3, 2) on a shared APB bus,
// checked against an array model of the register bank.
module tb_apb_slave_regbank;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_a [3];
  logic [2:0]  pready_a;
  logic [2:0]  pslverr_a;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] mdl [3][16];
  int wc [3] = '{0, 3, 2};

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_regbank #(
      .BASE_ADDR   (32'h8000_0000),
      .DEPTH       (16),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .hclk    (hclk),
      .hreset  (hreset),
      .psel    (psel[g]),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_SLVERR_EN
      .pslverr (pslverr_a[g]),
`endif
      .prdata  (prdata_a[g]),
      .pready  (pready_a[g])
    );
  end

`ifndef APB_SLVERR_EN
  assign pslverr_a = 3'b000;
`endif

  // Reference model: word offset from base selects one of 16 words; anything else is out of range.
  function automatic logic mdl_oor(input logic [31:0] a);
    return ((a - 32'h8000_0000) / 32'd4) >= 32'd16;
  endfunction

  function automatic logic [31:0] mdl_access(input int d, input logic wr,
                                             input logic [31:0] a, input logic [31:0] wd);
    int idx;
    if (mdl_oor(a)) return 32'h0;
    idx = int'((a - 32'h8000_0000) / 32'd4);
    if (wr) begin
      mdl[d][idx] = wd;
      return 32'h0;
    end
    return mdl[d][idx];
  endfunction

  function automatic void mdl_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++)
        mdl[d][i] = 32'h0;
  endfunction

  // One APB transfer; access-phase bus values are scrambled since the completer must ignore them.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int acc, output logic clean);
    psel = 3'b001 << d; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge hclk);
    clean = (pready_a[d] === 1'b0) && (prdata_a[d] === 32'h0) && (pslverr_a[d] === 1'b0);
    @(posedge hclk); #1;
    penable = 1'b1; paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom_range(0, 1));
    acc = 0; rd = 32'hx; err = 1'bx;
    while (acc < 20) begin
      @(negedge hclk);
      acc++;
      if (pready_a[d] === 1'b1) begin
        rd = prdata_a[d]; err = pslverr_a[d];
        break;
      end
      if (prdata_a[d] !== 32'h0 || pslverr_a[d] !== 1'b0) clean = 1'b0;
      @(posedge hclk); #1;
    end
    @(posedge hclk); #1;
  endtask

  task automatic idle();
    psel = 3'b000; penable = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err, clean; int acc;
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0; hreset = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (pready_a[d] !== 1'b0 || prdata_a[d] !== 32'h0 || pslverr_a[d] !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_outputs dut%0d: got pready=%b prdata=%h pslverr=%b expected 0/0/0",
                 d, pready_a[d], prdata_a[d], pslverr_a[d]);
      end
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    mdl_clear();
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0, rd, err, acc, clean);
      n_checks++;
      if (rd !== 32'h0 || acc != 1 || !clean || err !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_read reg%0d: got prdata=%h acc=%0d clean=%b err=%b expected 0/1/1/0",
                 i, rd, acc, clean, err);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err, clean; int acc;
    xfer(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, rd, err, acc, clean);
    void'(mdl_access(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF));
    n_checks++;
    if (acc != 1 || rd !== 32'h0) begin
      n_fails++;
      $display("FAIL wr0_write: got acc=%0d prdata=%h expected 1/00000000", acc, rd);
    end
    idle();
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, rd, err, acc, clean);
    n_checks++;
    if (acc != 1 || rd !== 32'hDEAD_BEEF || !clean) begin
      n_fails++;
      $display("FAIL wr0_read: got acc=%0d prdata=%h clean=%b expected 1/deadbeef/1", acc, rd, clean);
    end
    idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err, clean; int acc;
    xfer(1, 1'b1, 32'h8000_0004, 32'h1234_5678, rd, err, acc, clean);
    void'(mdl_access(1, 1'b1, 32'h8000_0004, 32'h1234_5678));
    n_checks++;
    if (acc != 4 || rd !== 32'h0) begin
      n_fails++;
      $display("FAIL wait3_write: got acc=%0d prdata=%h expected 4/00000000", acc, rd);
    end
    xfer(1, 1'b0, 32'h8000_0004, 32'h0, rd, err, acc, clean);
    n_checks++;
    if (acc != 4 || rd !== 32'h1234_5678 || !clean) begin
      n_fails++;
      $display("FAIL wait3_read: got acc=%0d prdata=%h clean=%b expected 4/12345678/1", acc, rd, clean);
    end
    psel = 3'b000; penable = 1'b0;
    @(negedge hclk);
    n_checks++;
    if (pready_a[1] !== 1'b0 || prdata_a[1] !== 32'h0) begin
      n_fails++;
      $display("FAIL wait3_after: got pready=%b prdata=%h expected 0/00000000", pready_a[1], prdata_a[1]);
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err, clean; int acc;
    xfer(0, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, rd, err, acc, clean);
    void'(mdl_access(0, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF));
    n_checks++;
    if (acc != 1 || rd !== 32'h0) begin
      n_fails++;
      $display("FAIL oor_write: got acc=%0d prdata=%h expected 1/00000000", acc, rd);
    end
`ifdef APB_SLVERR_EN
    n_checks++;
    if (err !== 1'b1) begin
      n_fails++;
      $display("FAIL oor_write_err: got pslverr=%b expected 1", err);
    end
`endif
    xfer(0, 1'b0, 32'h8000_0040, 32'h0, rd, err, acc, clean);
    n_checks++;
    if (acc != 1 || rd !== 32'h0 || !clean) begin
      n_fails++;
      $display("FAIL oor_read: got acc=%0d prdata=%h clean=%b expected 1/00000000/1", acc, rd, clean);
    end
`ifdef APB_SLVERR_EN
    n_checks++;
    if (err !== 1'b1) begin
      n_fails++;
      $display("FAIL oor_read_err: got pslverr=%b expected 1", err);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0, rd, err, acc, clean);
      n_checks++;
      if (rd !== mdl[0][i] || err !== 1'b0) begin
        n_fails++;
        $display("FAIL oor_bank reg%0d: got %h err=%b expected %h err=0", i, rd, err, mdl[0][i]);
      end
    end
    idle();
  endtask

  task automatic test_abort_and_reset();
    logic [31:0] rd; logic err, clean; int acc;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_000C; pwdata = 32'hA5A5_A5A5;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    psel = 3'b000; penable = 1'b0;
    @(negedge hclk);
    n_checks++;
    if (pready_a[2] !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_pready: got %b expected 0", pready_a[2]);
    end
    @(posedge hclk); #1;
    xfer(2, 1'b0, 32'h8000_000C, 32'h0, rd, err, acc, clean);
    n_checks++;
    if (rd !== mdl[2][3] || acc != 3) begin
      n_fails++;
      $display("FAIL abort_read: got prdata=%h acc=%0d expected %h/3", rd, acc, mdl[2][3]);
    end
    idle();
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_000C; pwdata = 32'hA5A5_A5A5;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0; psel = 3'b000; penable = 1'b0;
    mdl_clear();
    @(negedge hclk);
    n_checks++;
    if (pready_a[2] !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_mid_pready: got %b expected 0", pready_a[2]);
    end
    @(posedge hclk); #1;
    xfer(2, 1'b0, 32'h8000_000C, 32'h0, rd, err, acc, clean);
    n_checks++;
    if (rd !== 32'h0 || acc != 3) begin
      n_fails++;
      $display("FAIL rst_mid_read: got prdata=%h acc=%0d expected 00000000/3", rd, acc);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err, clean; int acc;
    logic [31:0] addrs [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0000, 32'h8000_0004};
    logic [31:0] wds   [4] = '{32'h1, 32'h2, 32'h0, 32'h0};
    logic        wrs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps  [4] = '{32'h0, 32'h0, 32'h1, 32'h2};
    for (int k = 0; k < 4; k++) begin
      xfer(0, wrs[k], addrs[k], wds[k], rd, err, acc, clean);
      void'(mdl_access(0, wrs[k], addrs[k], wds[k]));
      n_checks++;
      if (rd !== exps[k] || acc != 1 || !clean) begin
        n_fails++;
        $display("FAIL b2b xfer%0d: got prdata=%h acc=%0d clean=%b expected %h/1/1",
                 k, rd, acc, clean, exps[k]);
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd; logic err, clean, wr; int acc;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 40; k++) begin
        case ($urandom_range(0, 7))
          0:       a = 32'h8000_0040 + 32'($urandom_range(0, 255));
          1:       a = 32'h8000_0000 - 32'($urandom_range(1, 64));
          default: a = 32'h8000_0000 + 32'($urandom_range(0, 63));
        endcase
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        xfer(d, wr, a, wd, rd, err, acc, clean);
        exp_rd = mdl_access(d, wr, a, wd);
        n_checks++;
        if (rd !== exp_rd || acc != wc[d] + 1 || !clean) begin
          n_fails++;
          $display("FAIL rand dut%0d #%0d a=%h wr=%b: got prdata=%h acc=%0d clean=%b expected %h/%0d/1",
                   d, k, a, wr, rd, acc, clean, exp_rd, wc[d] + 1);
        end
`ifdef APB_SLVERR_EN
        n_checks++;
        if (err !== mdl_oor(a)) begin
          n_fails++;
          $display("FAIL rand_err dut%0d #%0d a=%h: got %b expected %b", d, k, a, err, mdl_oor(a));
        end
`endif
        if ($urandom_range(0, 2) == 0) idle();
      end
      idle();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_out_of_range();
    test_abort_and_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
